// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of hazard-controller inputs and stage controls between datapath and hazard_ctrl_unit.
// Optional statistics outputs are present only when HAZ_STATS_EN is defined.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_W = 5
);
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic             idex_MemRead;
    logic [REG_W-1:0] idex_RegDst;
    logic             exmem_RegWEN;
    logic [REG_W-1:0] exmem_RegDst;
    logic             mem_RegWEN;
    logic [REG_W-1:0] mem_RegDst;
    logic             dmem_req;
    logic             dhit;
    logic             ihit;
    logic             branch_taken;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             lu_stall;
`ifdef HAZ_STATS_EN
    logic [15:0]      stall_cycles;
    logic [15:0]      flush_count;
`endif

    modport slave (
        input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_MemRead, idex_RegDst,
        input  exmem_RegWEN, exmem_RegDst, mem_RegWEN, mem_RegDst,
        input  dmem_req, dhit, ihit, branch_taken,
        output forwardA, forwardB, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
`ifdef HAZ_STATS_EN
        output stall_cycles, flush_count,
`endif
        output ifid_flush, idex_flush, lu_stall
    );

    modport master (
        output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_MemRead, idex_RegDst,
        output exmem_RegWEN, exmem_RegDst, mem_RegWEN, mem_RegDst,
        output dmem_req, dhit, ihit, branch_taken,
        input  forwardA, forwardB, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
`ifdef HAZ_STATS_EN
        input  stall_cycles, flush_count,
`endif
        input  ifid_flush, idex_flush, lu_stall
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// 5-stage MIPS hazard controller: EX forwarding, load-use stall sequencer, dcache freeze,
// icache bubble and branch flush. Define HAZ_STATS_EN to add stall/flush statistics counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                CLK,
    input  logic                nRST,
    hazard_ctrl_unit_if.slave   bus
);
    localparam logic [REG_W-1:0] Zero = '0;

    typedef enum logic [0:0] {StRun, StLuWait} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_lud;
    logic             w_freeze;
    logic             w_stall_cond;

    assign w_lud = bus.idex_MemRead && (bus.idex_RegDst != Zero) &&
                   ((bus.idex_RegDst == bus.ifid_rs) || (bus.idex_RegDst == bus.ifid_rt));
    assign w_freeze     = bus.dmem_req && !bus.dhit;
    assign w_stall_cond = (r_state == StLuWait) || w_lud;

    // EX/MEM checked first so the younger result wins.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (bus.exmem_RegWEN && bus.exmem_RegDst != Zero && bus.exmem_RegDst == bus.idex_rs)
            w_fwd_a = 2'b10;
        else if (bus.mem_RegWEN && bus.mem_RegDst != Zero && bus.mem_RegDst == bus.idex_rs)
            w_fwd_a = 2'b01;
        if (bus.exmem_RegWEN && bus.exmem_RegDst != Zero && bus.exmem_RegDst == bus.idex_rt)
            w_fwd_b = 2'b10;
        else if (bus.mem_RegWEN && bus.mem_RegDst != Zero && bus.mem_RegDst == bus.idex_rt)
            w_fwd_b = 2'b01;
    end

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        bus.forwardA   = w_fwd_a;
        bus.forwardB   = w_fwd_b;
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.lu_stall   = 1'b0;
        if (!nRST) begin
            bus.forwardA = 2'b00;
            bus.forwardB = 2'b00;
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
        end else if (w_freeze) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
        end else if (bus.branch_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            w_state_d      = StRun;
            w_cnt_d        = '0;
        end else if (w_stall_cond) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            bus.lu_stall   = 1'b1;
            if (r_state == StRun) begin
                if (LOAD_STALL > 1) begin
                    w_state_d = StLuWait;
                    w_cnt_d   = CNT_W'(LOAD_STALL - 1);
                end
            end else begin
                w_cnt_d = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_d = StRun;
            end
        end else if (!bus.ihit) begin
            // ifid stays enabled so it captures the bubble.
            bus.pc_en      = 1'b0;
            bus.ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic        w_stall_evt;
    logic        w_flush_evt;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    assign w_flush_evt = !w_freeze && bus.branch_taken;
    assign w_stall_evt = w_freeze || (!bus.branch_taken && (w_stall_cond || !bus.ihit));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_evt && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_flush_evt && r_flush_count != 16'hFFFF)
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`endif
endmodule
